// File: rtl/adc_pack_9002_if.sv
// adc_pack_9002_if: sample bus in, packed word stream out, overflow status.
// master drives samples/ready/ovf_clr; slave (the packer) drives the packed side.
interface adc_pack_9002_if;
    logic [63:0] adc_data;
    logic [3:0]  adc_enable;
    logic [3:0]  adc_valid;
    logic [63:0] packed_data;
    logic        packed_valid;
    logic        packed_ready;
    logic        packed_sync;
    logic        adc_ovf;
    logic        adc_ovf_sticky;
    logic        ovf_clr;

    modport master (
        output adc_data,
        output adc_enable,
        output adc_valid,
        output packed_ready,
        output ovf_clr,
        input  packed_data,
        input  packed_valid,
        input  packed_sync,
        input  adc_ovf,
        input  adc_ovf_sticky
    );

    modport slave (
        input  adc_data,
        input  adc_enable,
        input  adc_valid,
        input  packed_ready,
        input  ovf_clr,
        output packed_data,
        output packed_valid,
        output packed_sync,
        output adc_ovf,
        output adc_ovf_sticky
    );
endinterface

// File: rtl/adc_pack_9002.sv
// adc_pack_9002: packs enabled 16-bit ADC lanes densely into 64-bit words.
// Ports: adc_clk, adc_rst (sync, active-high), bus (adc_pack_9002_if.slave).
// Optional PACK_PARTIAL_FLUSH_EN: emit zero-padded partial word on reconfig.
module adc_pack_9002 (
    input  logic              adc_clk,
    input  logic              adc_rst,
    adc_pack_9002_if.slave    bus
);

`ifdef PACK_PARTIAL_FLUSH_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1
    } state_t;
`endif

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_en_q;
    logic [127:0]   r_acc;
    logic [127:0]   w_acc_nxt;
    logic [2:0]     r_fill;
    logic [2:0]     w_fill_nxt;
    logic           r_sync_pend;
    logic           w_sync_pend_nxt;
    logic [63:0]    r_out_data;
    logic [63:0]    w_out_data_nxt;
    logic           r_out_valid;
    logic           w_out_valid_nxt;
    logic           r_out_sync;
    logic           w_out_sync_nxt;
    logic           r_ovf;
    logic           w_ovf_nxt;
    logic           r_sticky;
    logic           w_sticky_nxt;
`ifdef PACK_PARTIAL_FLUSH_EN
    logic           r_flush_sync;
    logic           w_flush_sync_nxt;
`endif

    logic           w_change;
    logic           w_strobe;
    logic           w_can_load;
    logic [63:0]    w_lanes;
    logic [2:0]     w_n;
    logic [127:0]   w_app;
    logic [2:0]     w_sum;
    logic           w_word_vld;
    logic [63:0]    w_word;
    logic           w_word_sync;

    assign w_change   = (bus.adc_enable != r_en_q);
    assign w_strobe   = |(bus.adc_valid & bus.adc_enable);
    assign w_can_load = !r_out_valid || bus.packed_ready;

    // Compact the enabled lanes (registered enables) into the low units.
    always_comb begin : p_lanes
        w_lanes = '0;
        w_n     = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_en_q[k]) begin
                w_lanes = w_lanes
                        | ({48'd0, bus.adc_data[16*k +: 16]} << {w_n, 4'd0});
                w_n     = w_n + 3'd1;
            end
        end
    end

    // Fill is at most 3 before an append, so the sum never exceeds 7.
    assign w_app = r_acc | ({64'd0, w_lanes} << {r_fill, 4'd0});
    assign w_sum = r_fill + w_n;

    always_comb begin : p_next
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_fill_nxt      = r_fill;
        w_sync_pend_nxt = r_sync_pend;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid && !bus.packed_ready;
        w_out_sync_nxt  = r_out_sync;
        w_ovf_nxt       = 1'b0;
        w_sticky_nxt    = r_sticky;
        w_word_vld      = 1'b0;
        w_word          = '0;
        w_word_sync     = 1'b0;
`ifdef PACK_PARTIAL_FLUSH_EN
        w_flush_sync_nxt = r_flush_sync;
`endif

        unique case (r_state)
            ST_IDLE: begin
                if (w_change) begin
                    w_acc_nxt       = '0;
                    w_fill_nxt      = '0;
                    w_sync_pend_nxt = 1'b1;
                    if (bus.adc_enable != 4'd0)
                        w_state_nxt = ST_PACK;
                end
            end
            ST_PACK: begin
                if (w_change) begin
                    w_sync_pend_nxt = 1'b1;
`ifdef PACK_PARTIAL_FLUSH_EN
                    if (r_fill != 3'd0) begin
                        // Keep the partial data; its own sync flag
                        // travels with it into FLUSH.
                        w_flush_sync_nxt = r_sync_pend;
                        w_state_nxt      = ST_FLUSH;
                    end else begin
                        w_acc_nxt  = '0;
                        w_fill_nxt = '0;
                        if (bus.adc_enable == 4'd0)
                            w_state_nxt = ST_IDLE;
                    end
`else
                    w_acc_nxt  = '0;
                    w_fill_nxt = '0;
                    if (bus.adc_enable == 4'd0)
                        w_state_nxt = ST_IDLE;
`endif
                end else if (w_strobe) begin
                    if (w_sum >= 3'd4) begin
                        w_word_vld  = 1'b1;
                        w_word      = w_app[63:0];
                        w_word_sync = r_sync_pend;
                        w_acc_nxt   = w_app >> 64;
                        w_fill_nxt  = w_sum - 3'd4;
                        // A dropped sync word leaves sync pending.
                        if (w_can_load)
                            w_sync_pend_nxt = 1'b0;
                    end else begin
                        w_acc_nxt  = w_app;
                        w_fill_nxt = w_sum;
                    end
                end
            end
`ifdef PACK_PARTIAL_FLUSH_EN
            ST_FLUSH: begin
                if (w_change)
                    w_sync_pend_nxt = 1'b1;
                // Wait here while the output slot is blocked.
                if (w_can_load) begin
                    w_word_vld  = 1'b1;
                    w_word      = r_acc[63:0];
                    w_word_sync = r_flush_sync;
                    w_acc_nxt   = '0;
                    w_fill_nxt  = '0;
                    if (bus.adc_enable == 4'd0)
                        w_state_nxt = ST_IDLE;
                    else
                        w_state_nxt = ST_PACK;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_word_vld) begin
            if (w_can_load) begin
                w_out_data_nxt  = w_word;
                w_out_valid_nxt = 1'b1;
                w_out_sync_nxt  = w_word_sync;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end

        if (w_ovf_nxt)
            w_sticky_nxt = 1'b1;
        else if (bus.ovf_clr)
            w_sticky_nxt = 1'b0;
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state     <= ST_IDLE;
            r_en_q      <= '0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_sync_pend <= 1'b1;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sync  <= 1'b0;
            r_ovf       <= 1'b0;
            r_sticky    <= 1'b0;
`ifdef PACK_PARTIAL_FLUSH_EN
            r_flush_sync <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_en_q      <= bus.adc_enable;
            r_acc       <= w_acc_nxt;
            r_fill      <= w_fill_nxt;
            r_sync_pend <= w_sync_pend_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sync  <= w_out_sync_nxt;
            r_ovf       <= w_ovf_nxt;
            r_sticky    <= w_sticky_nxt;
`ifdef PACK_PARTIAL_FLUSH_EN
            r_flush_sync <= w_flush_sync_nxt;
`endif
        end
    end

    assign bus.packed_data    = r_out_data;
    assign bus.packed_valid   = r_out_valid;
    assign bus.packed_sync    = r_out_sync;
    assign bus.adc_ovf        = r_ovf;
    assign bus.adc_ovf_sticky = r_sticky;

endmodule

// File: tb/tb_adc_pack_9002.sv
// tb_adc_pack_9002: directed + random stimulus against a queue-based model.
// Model keeps captured samples as a FIFO of 16-bit units.
module tb_adc_pack_9002;

    logic clk = 1'b0;
    logic rst;

    adc_pack_9002_if bus_if ();

    adc_pack_9002 dut (
        .adc_clk (clk),
        .adc_rst (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    logic [15:0] m_q[$];
    logic [3:0]  m_en_q;
    logic        m_sync_pend;
    logic        m_out_v;
    logic [63:0] m_out_d;
    logic        m_out_s;
    logic        m_ovf;
    logic        m_sticky;
    logic        m_flushing;
    logic        m_flush_sync;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_en_q       = '0;
        m_sync_pend  = 1'b1;
        m_out_v      = 1'b0;
        m_out_d      = '0;
        m_out_s      = 1'b0;
        m_ovf        = 1'b0;
        m_sticky     = 1'b0;
        m_flushing   = 1'b0;
        m_flush_sync = 1'b0;
    endtask

    function automatic logic [63:0] take_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (m_q.size() > 0)
                w[16*i +: 16] = m_q.pop_front();
        return w;
    endfunction

    task automatic model_step(input logic [3:0] en,
                              input logic [3:0] v,
                              input logic [63:0] d,
                              input logic rdy,
                              input logic clr);
        logic        can;
        logic        vld;
        logic        wsync;
        logic        from_pack;
        logic [63:0] w;
        can       = !m_out_v || rdy;
        vld       = 1'b0;
        wsync     = 1'b0;
        from_pack = 1'b0;
        w         = '0;
        m_out_v   = m_out_v && !rdy;
        if (m_flushing) begin
            if (en != m_en_q)
                m_sync_pend = 1'b1;
            if (can) begin
                w     = take_word();
                m_q.delete();
                vld   = 1'b1;
                wsync = m_flush_sync;
                m_flushing = 1'b0;
            end
        end else if (en != m_en_q) begin
`ifdef PACK_PARTIAL_FLUSH_EN
            if (m_en_q != 4'd0 && m_q.size() > 0) begin
                m_flushing   = 1'b1;
                m_flush_sync = m_sync_pend;
            end else begin
                m_q.delete();
            end
`else
            m_q.delete();
`endif
            m_sync_pend = 1'b1;
        end else if ((v & en) != 4'd0) begin
            for (int k = 0; k < 4; k++)
                if (en[k])
                    m_q.push_back(d[16*k +: 16]);
            if (m_q.size() >= 4) begin
                w         = take_word();
                vld       = 1'b1;
                wsync     = m_sync_pend;
                from_pack = 1'b1;
            end
        end
        m_ovf = 1'b0;
        if (vld) begin
            if (can) begin
                m_out_v = 1'b1;
                m_out_d = w;
                m_out_s = wsync;
                if (from_pack)
                    m_sync_pend = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_ovf)
            m_sticky = 1'b1;
        else if (clr)
            m_sticky = 1'b0;
        m_en_q = en;
    endtask

    task automatic step(input logic [3:0] en,
                        input logic [3:0] v,
                        input logic [63:0] d,
                        input logic rdy,
                        input logic clr,
                        input logic rs);
        @(negedge clk);
        rst                 = rs;
        bus_if.adc_enable   = en;
        bus_if.adc_valid    = v;
        bus_if.adc_data     = d;
        bus_if.packed_ready = rdy;
        bus_if.ovf_clr      = clr;
        if (rs)
            model_reset();
        else
            model_step(en, v, d, rdy, clr);
        @(posedge clk);
        #1;
        chk("valid", {63'd0, bus_if.packed_valid}, {63'd0, m_out_v});
        chk("data", bus_if.packed_data, m_out_d);
        chk("sync", {63'd0, bus_if.packed_sync}, {63'd0, m_out_s});
        chk("ovf", {63'd0, bus_if.adc_ovf}, {63'd0, m_ovf});
        chk("sticky", {63'd0, bus_if.adc_ovf_sticky},
            {63'd0, m_sticky});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    localparam logic [63:0] TP1 = 64'h4444_3333_2222_1111;

    initial begin
        logic [63:0] d;
        logic [3:0]  en;
        model_reset();
        rst = 1'b1;
        bus_if.adc_enable   = '0;
        bus_if.adc_valid    = '0;
        bus_if.adc_data     = '0;
        bus_if.packed_ready = 1'b1;
        bus_if.ovf_clr      = 1'b0;

        // reset state
        step(4'h0, 4'h0, 64'd0, 1'b1, 1'b0, 1'b1);
        step(4'h0, 4'h0, 64'd0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", {63'd0, bus_if.packed_valid}, 64'd0);
        chk("rst_data", bus_if.packed_data, 64'd0);

        // full-width streaming, first word tagged
        step(4'hF, 4'h0, TP1, 1'b1, 1'b0, 1'b0);
        step(4'hF, 4'hF, TP1, 1'b1, 1'b0, 1'b0);
        chk("tp1_first", bus_if.packed_data, TP1);
        chk("tp1_sync1", {63'd0, bus_if.packed_sync}, 64'd1);
        for (int i = 0; i < 4; i++)
            step(4'hF, 4'hF, TP1, 1'b1, 1'b0, 1'b0);
        chk("tp1_data", bus_if.packed_data, TP1);
        chk("tp1_sync0", {63'd0, bus_if.packed_sync}, 64'd0);

        // lanes 0 and 2
        step(4'h5, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            d = '0;
            d[15:0]  = 16'h00A0 + 16'(n);
            d[47:32] = 16'h00B0 + 16'(n);
            step(4'h5, 4'h5, d, 1'b1, 1'b0, 1'b0);
            if (n == 1)
                chk("tp2_w0", bus_if.packed_data,
                    64'h00B1_00A1_00B0_00A0);
        end
        chk("tp2_w1", bus_if.packed_data, 64'h00B3_00A3_00B2_00A2);

        // three lanes, carry across words
        step(4'h7, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++)
            step(4'h7, 4'h7, rnd64(), 1'b1, 1'b0, 1'b0);
        chk("tp3_fill0", 64'(m_q.size()), 64'd0);

        // stall: word held, overflow pulses, sticky until cleared
        step(4'hF, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(4'hF, 4'hF, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(4'hF, 4'hF, rnd64(), 1'b0, 1'b0, 1'b0);
        chk("tp4_hold", bus_if.packed_data, 64'h1234_5678_9ABC_DEF0);
        chk("tp4_sticky", {63'd0, bus_if.adc_ovf_sticky}, 64'd1);
        step(4'hF, 4'h0, 64'd0, 1'b1, 1'b1, 1'b0);
        chk("tp4_clr", {63'd0, bus_if.adc_ovf_sticky}, 64'd0);

        // partial word at reconfiguration
        step(4'h3, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(4'h3, 4'h3, 64'h0000_0000_BEEF_CAFE, 1'b1, 1'b0, 1'b0);
        step(4'hC, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(4'hC, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
`ifdef PACK_PARTIAL_FLUSH_EN
        chk("tp5_flush", bus_if.packed_data, 64'h0000_0000_BEEF_CAFE);
`else
        chk("tp5_noword", {63'd0, bus_if.packed_valid}, 64'd0);
`endif
        step(4'hC, 4'hC, rnd64(), 1'b1, 1'b0, 1'b0);
        step(4'hC, 4'hC, rnd64(), 1'b1, 1'b0, 1'b0);
        chk("tp5_sync", {63'd0, bus_if.packed_sync}, 64'd1);

        // reset during stall
        step(4'hF, 4'hF, rnd64(), 1'b0, 1'b0, 1'b0);
        step(4'hF, 4'hF, rnd64(), 1'b0, 1'b0, 1'b0);
        step(4'hF, 4'hF, rnd64(), 1'b0, 1'b0, 1'b1);
        chk("tp6_valid", {63'd0, bus_if.packed_valid}, 64'd0);
        chk("tp6_sticky", {63'd0, bus_if.adc_ovf_sticky}, 64'd0);
        step(4'hF, 4'h0, 64'd0, 1'b1, 1'b0, 1'b0);
        step(4'hF, 4'h1, rnd64(), 1'b1, 1'b0, 1'b0);
        chk("tp6_sync", {63'd0, bus_if.packed_sync}, 64'd1);

        // random traffic
        en = 4'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                en = 4'($urandom_range(0, 15));
            step(en, 4'($urandom()), rnd64(),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
